// File: rtl/wb_stream_pkg.sv
// wb_stream_pkg
// Shared constants for the Wishbone stream writer: cycle-type and burst-type
// encodings driven on the bus, and the controller FSM state encoding.
// No ports (package).
package wb_stream_pkg;

  // Wishbone registered-feedback cycle types
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst type: linear incrementing only
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Controller FSM states
  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] WAIT_ROOM   = 2'd1;
  localparam logic [1:0] BURST       = 2'd2;

endpackage

// File: rtl/wb_stream_writer_ctrl_if.sv
// wb_stream_writer_ctrl_if
// Bundles the Wishbone master bus and the outgoing valid/ready stream of the
// stream writer controller.
//   master modport : controller side (drives wbm_*_o and stream_m_*_o)
//   slave modport  : memory/sink side (drives wbm_*_i and stream_m_ready_i)
// Optional macro WB_STREAM_WRITER_LAST_EN adds stream_m_last_o.
interface wb_stream_writer_ctrl_if #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32
);
  logic [WB_AW-1:0]   wbm_adr_o;
  logic [WB_DW-1:0]   wbm_dat_o;
  logic [WB_DW/8-1:0] wbm_sel_o;
  logic               wbm_we_o;
  logic               wbm_cyc_o;
  logic               wbm_stb_o;
  logic [2:0]         wbm_cti_o;
  logic [1:0]         wbm_bte_o;
  logic [WB_DW-1:0]   wbm_dat_i;
  logic               wbm_ack_i;
  logic               wbm_err_i;
  logic               wbm_rty_i;
  logic [WB_DW-1:0]   stream_m_data_o;
  logic               stream_m_valid_o;
  logic               stream_m_ready_i;
`ifdef WB_STREAM_WRITER_LAST_EN
  logic               stream_m_last_o;
`endif

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
           wbm_cti_o, wbm_bte_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    output stream_m_data_o, stream_m_valid_o,
`ifdef WB_STREAM_WRITER_LAST_EN
    output stream_m_last_o,
`endif
    input  stream_m_ready_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
           wbm_cti_o, wbm_bte_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    input  stream_m_data_o, stream_m_valid_o,
`ifdef WB_STREAM_WRITER_LAST_EN
    input  stream_m_last_o,
`endif
    output stream_m_ready_i
  );
endinterface

// File: rtl/wb_stream_writer_fifo.sv
// wb_stream_writer_fifo
// First-word-fall-through FIFO built from a RAM array with a registered read
// port; the read register doubles as the output holding stage.
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset (flushes)
//   push, push_data    : write side (caller never pushes when full)
//   pop                : consume the head word (only when valid)
//   pop_data, valid    : head word and non-empty flag
//   level              : total words held (RAM + output stage), 0..2^AW
module wb_stream_writer_fifo #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          valid,
  output logic [AW:0]   level
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [0:DEPTH-1];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   ram_cnt_reg;
  logic [DW-1:0] dout_reg;
  logic          valid_reg;
  logic          rd_en;

  // Refill the output stage whenever it is empty or being consumed. The RAM
  // read never targets the slot being written: rd_en needs ram_cnt != 0.
  assign rd_en = (ram_cnt_reg != '0) && (!valid_reg || pop);

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge wb_clk_i) begin
    if (rd_en) dout_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      ram_cnt_reg <= '0;
      valid_reg   <= 1'b0;
    end else begin
      if (push)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      ram_cnt_reg <= ram_cnt_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, rd_en};
      if (rd_en)    valid_reg <= 1'b1;
      else if (pop) valid_reg <= 1'b0;
    end
  end

  assign pop_data = dout_reg;
  assign valid    = valid_reg;
  assign level    = ram_cnt_reg + {{AW{1'b0}}, valid_reg};
endmodule

// File: rtl/wb_stream_writer_ctrl.sv
// wb_stream_writer_ctrl
// Wishbone burst read master: fetches buf_size bytes from start_adr in bursts
// of burst_size words and emits them on a valid/ready stream via an internal
// FIFO. A burst is only issued when the FIFO can absorb all of it.
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   bus                : Wishbone master + stream (master modport)
//   enable             : single-cycle start pulse (ignored while busy)
//   start_adr          : buffer start, byte address
//   buf_size           : buffer length in bytes (low 2 bits ignored)
//   burst_size         : burst length in words (clamped to 1..FIFO depth)
//   busy               : memory fetch in progress
//   tx_cnt             : words fetched in current/last transfer
// Optional macro WB_STREAM_WRITER_LAST_EN adds a last flag per word.
module wb_stream_writer_ctrl
  import wb_stream_pkg::*;
#(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 6
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  wb_stream_writer_ctrl_if.master bus,
  input  logic                    enable,
  input  logic [WB_AW-1:0]        start_adr,
  input  logic [WB_AW-1:0]        buf_size,
  input  logic [WB_AW-1:0]        burst_size,
  output logic                    busy,
  output logic [WB_DW-1:0]        tx_cnt
);
  localparam int              DEPTH   = 1 << FIFO_AW;
  localparam logic [WB_AW-1:0] DEPTH_W = WB_AW'(DEPTH);
`ifdef WB_STREAM_WRITER_LAST_EN
  localparam int FW = WB_DW + 1;
`else
  localparam int FW = WB_DW;
`endif

  logic [1:0]       state_reg;
  logic [WB_AW-1:0] adr_reg, remaining_reg;
  logic [WB_DW-1:0] tx_cnt_reg;
  logic [FIFO_AW:0] beat_reg, burst_len_reg;
  logic             busy_reg;

  logic [WB_AW-1:0] words, blen_cfg, burst_len_cur;
  logic [FIFO_AW:0] level, free_slots;
  logic             last_beat, push, pop, fifo_valid;
  logic [FW-1:0]    push_data, pop_data;
  logic [3:0]       unused_bits;

  assign unused_bits = {buf_size[1:0], start_adr[1:0]};

  assign words = {2'b00, buf_size[WB_AW-1:2]};

  always_comb begin
    blen_cfg = burst_size;
    if (burst_size == '0)          blen_cfg = WB_AW'(1);
    else if (burst_size > DEPTH_W) blen_cfg = DEPTH_W;
  end

  assign burst_len_cur = (blen_cfg < remaining_reg) ? blen_cfg : remaining_reg;
  assign free_slots    = (FIFO_AW+1)'(DEPTH) - level;
  assign last_beat     = (beat_reg == burst_len_reg - 1'b1);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg     <= IDLE;
      adr_reg       <= '0;
      remaining_reg <= '0;
      tx_cnt_reg    <= '0;
      beat_reg      <= '0;
      burst_len_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable && words != '0) begin
            adr_reg       <= {start_adr[WB_AW-1:2], 2'b00};
            remaining_reg <= words;
            tx_cnt_reg    <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= WAIT_ROOM;
          end
        end
        WAIT_ROOM: begin
          // burst_len_cur never exceeds DEPTH, so the narrowing is lossless
          if (WB_AW'(free_slots) >= burst_len_cur) begin
            burst_len_reg <= burst_len_cur[FIFO_AW:0];
            beat_reg      <= '0;
            state_reg     <= BURST;
          end
        end
        BURST: begin
          // err wins over a simultaneous ack; rty is simply not an ack
          if (bus.wbm_err_i) begin
            beat_reg  <= '0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (bus.wbm_ack_i) begin
            adr_reg       <= adr_reg + WB_AW'(4);
            tx_cnt_reg    <= tx_cnt_reg + WB_DW'(1);
            remaining_reg <= remaining_reg - WB_AW'(1);
            beat_reg      <= beat_reg + 1'b1;
            if (last_beat) begin
              beat_reg <= '0;
              if (remaining_reg == WB_AW'(1)) begin
                busy_reg  <= 1'b0;
                state_reg <= IDLE;
              end else begin
                state_reg <= WAIT_ROOM;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign push = (state_reg == BURST) && bus.wbm_ack_i && !bus.wbm_err_i;
  assign pop  = fifo_valid && bus.stream_m_ready_i;

`ifdef WB_STREAM_WRITER_LAST_EN
  assign push_data = {remaining_reg == WB_AW'(1), bus.wbm_dat_i};
  assign bus.stream_m_last_o = pop_data[WB_DW];
`else
  assign push_data = bus.wbm_dat_i;
`endif

  wb_stream_writer_fifo #(.DW(FW), .AW(FIFO_AW)) u_fifo (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .valid     (fifo_valid),
    .level     (level)
  );

  assign bus.wbm_adr_o        = adr_reg;
  assign bus.wbm_dat_o        = '0;
  assign bus.wbm_sel_o        = '1;
  assign bus.wbm_we_o         = 1'b0;
  assign bus.wbm_cyc_o        = (state_reg == BURST);
  assign bus.wbm_stb_o        = (state_reg == BURST);
  assign bus.wbm_cti_o        = (state_reg != BURST) ? CTI_CLASSIC :
                                (last_beat ? CTI_EOB : CTI_INC);
  assign bus.wbm_bte_o        = BTE_LINEAR;
  assign bus.stream_m_data_o  = pop_data[WB_DW-1:0];
  assign bus.stream_m_valid_o = fifo_valid;

  assign busy   = busy_reg;
  assign tx_cnt = tx_cnt_reg;
endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
module tb_wb_stream_writer_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] start_adr = '0, buf_size = '0, burst_size = '0;
  logic        busy;
  logic [31:0] tx_cnt;

  wb_stream_writer_ctrl_if bus();

  wb_stream_writer_ctrl #(.WB_AW(32), .WB_DW(32), .FIFO_AW(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .bus        (bus),
    .enable     (enable),
    .start_adr  (start_adr),
    .buf_size   (buf_size),
    .burst_size (burst_size),
    .busy       (busy),
    .tx_cnt     (tx_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0, fails = 0;

  // slave / sink / monitor state
  int          acked, pops, bursts, rty_at, err_at, rty_seen, fall_acked;
  logic [31:0] rty_adr;
  logic [31:0] ack_adr [0:63];
  logic [2:0]  ack_cti [0:63];
  logic [31:0] pop_dat [0:63];
  logic        pop_last [0:63];
  int          rise_pops [0:7];
  logic        cyc_prev = 1'b0, busy_prev = 1'b0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  initial begin
    bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0; bus.wbm_rty_i = 1'b0;
    bus.wbm_dat_i = '0;   bus.stream_m_ready_i = 1'b0;
  end

  // Zero-wait Wishbone slave with rty/err injection, stream sink logger and
  // burst/busy monitor; all decisions made on the falling edge.
  always @(negedge clk) begin
    if (busy_prev && !busy) fall_acked = acked;
    busy_prev = busy;
    if (bus.wbm_cyc_o && !cyc_prev) begin
      if (bursts < 8) rise_pops[bursts] = pops;
      bursts++;
    end
    cyc_prev = bus.wbm_cyc_o;
    bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0; bus.wbm_rty_i = 1'b0;
    if (bus.wbm_cyc_o && bus.wbm_stb_o && !rst) begin
      bus.wbm_dat_i = memword(bus.wbm_adr_o);
      if (acked + 1 == err_at) begin
        bus.wbm_err_i = 1'b1;
      end else if (acked + 1 == rty_at && rty_seen == 0) begin
        bus.wbm_rty_i = 1'b1;
        rty_seen = 1;
        rty_adr = bus.wbm_adr_o;
      end else begin
        bus.wbm_ack_i = 1'b1;
        if (acked < 64) begin
          ack_adr[acked] = bus.wbm_adr_o;
          ack_cti[acked] = bus.wbm_cti_o;
        end
        acked++;
      end
    end
    if (bus.stream_m_valid_o && bus.stream_m_ready_i && !rst) begin
      if (pops < 64) begin
        pop_dat[pops] = bus.stream_m_data_o;
`ifdef WB_STREAM_WRITER_LAST_EN
        pop_last[pops] = bus.stream_m_last_o;
`else
        pop_last[pops] = 1'b0;
`endif
      end
      pops++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic clear_logs(input int rty_beat, input int err_beat);
    acked = 0; pops = 0; bursts = 0; rty_seen = 0; fall_acked = -1;
    rty_at = rty_beat; err_at = err_beat; rty_adr = '0;
  endtask

  task automatic start(input logic [31:0] sa, input logic [31:0] bs, input logic [31:0] bl);
    start_adr = sa; buf_size = bs; burst_size = bl;
    enable = 1'b1; step(); enable = 1'b0;
    $display("xfer start_adr=0x%08h buf_size=%0d burst_size=%0d", sa, bs, bl);
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    while (busy && n < maxc) begin step(); n++; end
    check({tag, "_idle_timeout"}, 32'(n < maxc), 32'd1);
  endtask

  task automatic wait_pops(input string tag, input int tgt, input int maxc);
    int n = 0;
    while (pops < tgt && n < maxc) begin step(); n++; end
    check({tag, "_pops"}, 32'(pops), 32'(tgt));
  endtask

  task automatic check_data(input string tag, input logic [31:0] sa, input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_data%0d", tag, i), pop_dat[i], memword(sa + 32'(4 * i)));
  endtask

  initial begin
    clear_logs(0, 0);
    repeat (3) step();
    // ---- reset state
    check("rst_cyc", 32'(bus.wbm_cyc_o), 0);
    check("rst_stb", 32'(bus.wbm_stb_o), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cti", 32'(bus.wbm_cti_o), 0);
    check("rst_adr", bus.wbm_adr_o, 0);
    check("rst_tx", tx_cnt, 0);
    check("rst_valid", 32'(bus.stream_m_valid_o), 0);
    check("rst_we", 32'(bus.wbm_we_o), 0);
    check("rst_sel", 32'(bus.wbm_sel_o), 32'hF);
    rst = 1'b0;
    step();

    // ---- words == 0 is ignored
    start(32'h0000_0800, 32'd3, 32'd4);
    check("zero_busy", 32'(busy), 0);
    repeat (3) step();
    check("zero_cyc", 32'(bus.wbm_cyc_o), 0);

    // ---- 64 bytes, bursts of 4, sink ready
    bus.stream_m_ready_i = 1'b1;
    clear_logs(0, 0);
    start(32'h0000_1000, 32'd64, 32'd4);
    check("t1_busy_rise", 32'(busy), 1);
    wait_idle("t1", 400);
    wait_pops("t1", 16, 50);
    check("t1_acks", 32'(acked), 16);
    check("t1_bursts", 32'(bursts), 4);
    check("t1_fall_acked", 32'(fall_acked), 16);
    check("t1_tx", tx_cnt, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t1_adr%0d", i), ack_adr[i], 32'h1000 + 32'(4 * i));
      check($sformatf("t1_cti%0d", i), 32'(ack_cti[i]), (i % 4 == 3) ? 32'h7 : 32'h2);
    end
    check_data("t1", 32'h1000, 16);

    // ---- 40 bytes, bursts 4,4,2
    clear_logs(0, 0);
    start(32'h0000_2000, 32'd40, 32'd4);
    wait_idle("t2", 400);
    wait_pops("t2", 10, 50);
    check("t2_bursts", 32'(bursts), 3);
    check("t2_tx", tx_cnt, 10);
    check("t2_cti8", 32'(ack_cti[8]), 32'h2);
    check("t2_cti9", 32'(ack_cti[9]), 32'h7);
    check("t2_cti7", 32'(ack_cti[7]), 32'h7);
    check("t2_adr8", ack_adr[8], 32'h2020);
    check_data("t2", 32'h2000, 10);

    // ---- sink stalled: first burst of 16 fills the FIFO
    bus.stream_m_ready_i = 1'b0;
    clear_logs(0, 0);
    start(32'h0000_3000, 32'd128, 32'd16);
    repeat (60) step();
    check("t3_bursts_stall", 32'(bursts), 1);
    check("t3_acks_stall", 32'(acked), 16);
    check("t3_cyc_stall", 32'(bus.wbm_cyc_o), 0);
    check("t3_busy_stall", 32'(busy), 1);
    check("t3_valid_stall", 32'(bus.stream_m_valid_o), 1);
    bus.stream_m_ready_i = 1'b1;
    wait_idle("t3", 400);
    wait_pops("t3", 32, 50);
    check("t3_bursts", 32'(bursts), 2);
    check("t3_rise_pops", 32'(rise_pops[1]), 16);
    check("t3_tx", tx_cnt, 32);
    check_data("t3", 32'h3000, 32);

    // ---- retry on beat 2
    clear_logs(2, 0);
    start(32'h0000_4000, 32'd16, 32'd4);
    wait_idle("t4", 200);
    wait_pops("t4", 4, 50);
    check("t4_rty_seen", 32'(rty_seen), 1);
    check("t4_rty_adr", rty_adr, 32'h4004);
    check("t4_adr1", ack_adr[1], 32'h4004);
    check("t4_acks", 32'(acked), 4);
    check("t4_tx", tx_cnt, 4);
    check_data("t4", 32'h4000, 4);

    // ---- error on beat 3 of 8
    clear_logs(0, 3);
    start(32'h0000_5000, 32'd32, 32'd8);
    wait_idle("t5", 200);
    check("t5_cyc", 32'(bus.wbm_cyc_o), 0);
    check("t5_tx", tx_cnt, 2);
    wait_pops("t5", 2, 50);
    repeat (5) step();
    check("t5_pops_final", 32'(pops), 2);
    check_data("t5", 32'h5000, 2);
    clear_logs(0, 0);
    start(32'h0000_5000, 32'd32, 32'd8);
    wait_idle("t5r", 200);
    wait_pops("t5r", 8, 50);
    check("t5r_adr0", ack_adr[0], 32'h5000);
    check("t5r_tx", tx_cnt, 8);
    check_data("t5r", 32'h5000, 8);

    // ---- reset mid-burst
    clear_logs(0, 0);
    start(32'h0000_6000, 32'd64, 32'd16);
    for (int n = 0; n < 50 && acked < 3; n++) step();
    check("t6_midburst", 32'(bus.wbm_cyc_o), 1);
    rst = 1'b1;
    step();
    check("t6_cyc", 32'(bus.wbm_cyc_o), 0);
    check("t6_valid", 32'(bus.stream_m_valid_o), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_tx", tx_cnt, 0);
    rst = 1'b0;
    step();

`ifdef WB_STREAM_WRITER_LAST_EN
    // ---- last flag only on final word
    clear_logs(0, 0);
    start(32'h0000_7000, 32'd32, 32'd4);
    wait_idle("t7", 200);
    wait_pops("t7", 8, 50);
    for (int i = 0; i < 8; i++)
      check($sformatf("t7_last%0d", i), 32'(pop_last[i]), (i == 7) ? 32'd1 : 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
